// File: rtl/i2s_stereo_tx.sv
// i2s_stereo_tx: stereo I2S / left-justified serializer with double-buffered samples and MCLK/BCLK/LRCK generation.
// Define I2S_STEREO_TX_UNDERRUN_CNT_EN to add the saturating oUnderrun_cnt output.
module i2s_stereo_tx #(
    parameter int SAMPLE_W      = 16,
    parameter int SLOT_W        = 32,
    parameter int BCLK_DIV      = 8,
    parameter int MCLK_DIV      = 2,
    parameter int FMT_LJ        = 0,
    parameter int UNDERRUN_MUTE = 1
) (
    input  logic                iCLK,
    input  logic                iRESET_n,
    input  logic [SAMPLE_W-1:0] iL_data,
    input  logic [SAMPLE_W-1:0] iR_data,
    input  logic                iValid,
    output logic                oReady,
    output logic                oMCLK,
    output logic                oBCLK,
    output logic                oLRCK,
    output logic                oSDATA,
`ifdef I2S_STEREO_TX_UNDERRUN_CNT_EN
    output logic [15:0]         oUnderrun_cnt,
`endif
    output logic                oUnderrun
);
    localparam int FW = 2*SLOT_W;
    localparam int MW = $clog2(MCLK_DIV);
    localparam int BW = $clog2(BCLK_DIV);
    localparam int CW = $clog2(FW);

    if (SLOT_W < SAMPLE_W || SAMPLE_W < 8 || SAMPLE_W > 32 || BCLK_DIV < 2 || BCLK_DIV % 2 != 0 ||
        MCLK_DIV < 2 || MCLK_DIV % 2 != 0) begin : g_param_err
        $error("i2s_stereo_tx: illegal parameter combination");
    end

    logic [MW-1:0]       r_mdiv;
    logic [BW-1:0]       r_bdiv;
    logic [CW-1:0]       r_bitc;
    logic                r_mclk, r_bclk, r_lrck, r_sdata, r_underrun;
    logic                r_hold_full, r_armed;
    logic [SAMPLE_W-1:0] r_hold_L, r_hold_R, r_sh_L, r_sh_R;
    logic [FW-1:0]       r_frame;

    logic                w_fe, w_load, w_xfer;
    logic [BW-1:0]       w_bdiv_nx;
    logic [CW-1:0]       w_bitc_nx;
    logic [SAMPLE_W-1:0] w_new_L, w_new_R;
    logic [FW-1:0]       w_frame_cur;

    always_comb begin
        w_fe        = r_bdiv == BW'(BCLK_DIV-1);
        w_bdiv_nx   = w_fe ? '0 : r_bdiv + 1'b1;
        w_bitc_nx   = (r_bitc == CW'(FW-1)) ? '0 : r_bitc + 1'b1;
        // I2S position lags the bit counter by one, so its next position is the current count
        w_load      = w_fe && (((FMT_LJ != 0) ? w_bitc_nx : r_bitc) == '0);
        w_xfer      = iValid && !r_hold_full;
        w_new_L     = r_hold_full ? r_hold_L : ((UNDERRUN_MUTE != 0) ? '0 : r_sh_L);
        w_new_R     = r_hold_full ? r_hold_R : ((UNDERRUN_MUTE != 0) ? '0 : r_sh_R);
        w_frame_cur = w_load ? ((FW'(w_new_L) << (FW-SAMPLE_W)) | (FW'(w_new_R) << (SLOT_W-SAMPLE_W)))
                             : r_frame;
    end

    always_ff @(posedge iCLK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_mdiv      <= '0;
            r_mclk      <= 1'b0;
            r_bdiv      <= '0;
            r_bclk      <= 1'b0;
            r_bitc      <= '0;
            r_lrck      <= 1'b0;
            r_sdata     <= 1'b0;
            r_underrun  <= 1'b0;
            r_hold_full <= 1'b0;
            r_armed     <= 1'b0;
            r_hold_L    <= '0;
            r_hold_R    <= '0;
            r_sh_L      <= '0;
            r_sh_R      <= '0;
            r_frame     <= '0;
        end else begin
            r_mdiv     <= (r_mdiv == MW'(MCLK_DIV/2-1)) ? '0 : r_mdiv + 1'b1;
            r_mclk     <= (r_mdiv == MW'(MCLK_DIV/2-1)) ? !r_mclk : r_mclk;
            r_bdiv     <= w_bdiv_nx;
            r_bclk     <= w_bdiv_nx >= BW'(BCLK_DIV/2);
            r_underrun <= w_load && !r_hold_full && r_armed;
            if (w_fe) begin
                r_bitc  <= w_bitc_nx;
                r_lrck  <= w_bitc_nx >= CW'(SLOT_W);
                r_sdata <= w_frame_cur[FW-1];
                r_frame <= w_frame_cur << 1;
            end
            if (w_load) begin
                r_sh_L <= w_new_L;
                r_sh_R <= w_new_R;
            end
            if (w_xfer) begin
                r_hold_L    <= iL_data;
                r_hold_R    <= iR_data;
                r_hold_full <= 1'b1;
                r_armed     <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

`ifdef I2S_STEREO_TX_UNDERRUN_CNT_EN
    logic [15:0] r_ucnt;

    always_ff @(posedge iCLK or negedge iRESET_n) begin
        if (!iRESET_n)
            r_ucnt <= '0;
        else if (r_underrun && r_ucnt != 16'hFFFF)
            r_ucnt <= r_ucnt + 16'd1;
    end

    assign oUnderrun_cnt = r_ucnt;
`endif

    assign oReady    = !r_hold_full;
    assign oMCLK     = r_mclk;
    assign oBCLK     = r_bclk;
    assign oLRCK     = r_lrck;
    assign oSDATA    = r_sdata;
    assign oUnderrun = r_underrun;
endmodule

// File: tb/tb_i2s_stereo_tx.sv
// tb_i2s_stereo_tx: three serializers (I2S mute, LJ mute, I2S repeat) checked every clock against a positional model.
module tb_i2s_stereo_tx;
    localparam int SW = 16, SLOT = 32, BD = 4, MD = 2, FW = 2*SLOT;
    localparam bit [2:0] LJ = 3'b010, MUTE = 3'b011;
    localparam logic [63:0] W = {16'hA55A, 16'h0000, 16'h8001, 16'h0000};

    logic clk = 1'b0, rst_n = 1'b1;
    logic [SW-1:0] dl = '0, dr = '0;
    logic [2:0] vld = '0, rdy, mclk, bclk, lrck, sd, un;
`ifdef I2S_STEREO_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        i2s_stereo_tx #(.SAMPLE_W(SW), .SLOT_W(SLOT), .BCLK_DIV(BD), .MCLK_DIV(MD),
                        .FMT_LJ(int'(LJ[g])), .UNDERRUN_MUTE(int'(MUTE[g]))) dut (
            .iCLK(clk), .iRESET_n(rst_n), .iL_data(dl), .iR_data(dr), .iValid(vld[g]),
            .oReady(rdy[g]), .oMCLK(mclk[g]), .oBCLK(bclk[g]), .oLRCK(lrck[g]), .oSDATA(sd[g]),
`ifdef I2S_STEREO_TX_UNDERRUN_CNT_EN
            .oUnderrun_cnt(ucnt[g]),
`endif
            .oUnderrun(un[g]));
    end

    always #5 clk = ~clk;

    int cyc, total, passed, failed, first_rise, guard;
    logic full [3], armed [3], und [3];
    logic [SW-1:0] hl [3], hr [3], pl [3], pr [3];
    int acc [3], upulse [3];
    logic [2:0] fe_sd [1024];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            full[i] = 0; armed[i] = 0; und[i] = 0;
            hl[i] = '0; hr[i] = '0; pl[i] = '0; pr[i] = '0;
        end
    endtask

    // Stream position after the current count, from the frame rules.
    function automatic int pos(int i);
        int bitc;
        bitc = (cyc / BD) % FW;
        return LJ[i] ? bitc : (bitc + FW - 1) % FW;
    endfunction

    task automatic model_edge();
        logic load, xfer;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            load = (cyc % BD == 0) && pos(i) == 0;
            xfer = vld[i] && !full[i];
            und[i] = load && !full[i] && armed[i];
            if (load) begin
                pl[i] = full[i] ? hl[i] : (MUTE[i] ? '0 : pl[i]);
                pr[i] = full[i] ? hr[i] : (MUTE[i] ? '0 : pr[i]);
            end
            if (xfer) begin
                hl[i] = dl; hr[i] = dr; full[i] = 1; armed[i] = 1;
            end else if (load) full[i] = 0;
        end
    endtask

    function automatic logic [5:0] exp_out(int i);
        int n, p;
        logic s;
        n = cyc / BD;
        p = pos(i);
        s = 1'b0;
        if (n > 0 && p < SW) s = pl[i][SW-1-p];
        else if (n > 0 && p >= SLOT && p < SLOT+SW) s = pr[i][SW-1-(p-SLOT)];
        return {1'((cyc / (MD/2)) % 2), (cyc % BD) >= BD/2, (n % FW) >= SLOT, s, !full[i], und[i]};
    endfunction

    function automatic logic [63:0] word(int i, int n0);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 64; k++) w = {w[62:0], fe_sd[n0+k][i]};
        return w;
    endfunction

    task automatic tick();
        if (rst_n) for (int i = 0; i < 3; i++) acc[i] += int'(vld[i] && rdy[i]);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("out%0d@%0d", i, cyc), 64'({mclk[i], bclk[i], lrck[i], sd[i], rdy[i], un[i]}),
                  64'(exp_out(i)));
            upulse[i] += int'(un[i]);
        end
        if (rst_n && cyc > 0 && cyc % BD == 0 && cyc / BD < 1024) fe_sd[cyc/BD] = sd;
        if (rst_n && first_rise == 0 && bclk[0]) first_rise = cyc;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin acc[i] = 0; upulse[i] = 0; end
    endtask

    initial begin
        total = 0; passed = 0; failed = 0; first_rise = 0;
        clear_counts();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_out%0d", i), 64'({mclk[i], bclk[i], lrck[i], sd[i], rdy[i], un[i]}), 64'(6'b000010));
        repeat (5) tick();
        rst_n = 1'b1;
        dl = 16'hA55A; dr = 16'h8001; vld = 3'b111;
        tick();
        vld = 3'b000;
        dl = 16'($urandom); dr = 16'($urandom);
        while (cyc < 252) tick();
        check("bclk_first_rise", 64'(first_rise), 64'd2);
        check("lj_lrck_before", 64'(lrck[1]), 64'd1);
        check("rep_lrck_sd_252", 64'({lrck[2], sd[2]}), 64'(2'b10));
        while (cyc < 256) tick();
        check("lj_msb_at_lrck_fall", 64'({lrck[1], sd[1]}), 64'(2'b01));
        check("rep_lrck_sd_256", 64'({lrck[2], sd[2]}), 64'(2'b00));
        while (cyc < 260) tick();
        check("rep_msb_one_bclk_late", 64'({lrck[2], sd[2]}), 64'(2'b01));
        while (cyc < 776) tick();
        check("i2s_frame1", word(0, 1), W);
        check("i2s_frame2_mute", word(0, 65), 64'd0);
        check("lj_frame1", word(1, 64), W);
        check("lj_frame2_mute", word(1, 128), 64'd0);
        check("rep_frame1", word(2, 1), W);
        check("rep_frame2", word(2, 65), W);
        check("rep_frame3", word(2, 129), W);
        check("i2s_underruns", 64'(upulse[0]), 64'd3);
        check("lj_underruns", 64'(upulse[1]), 64'd2);
        check("rep_underruns", 64'(upulse[2]), 64'd3);
        for (int i = 0; i < 3; i++) check($sformatf("xfers%0d", i), 64'(acc[i]), 64'd1);
`ifdef I2S_STEREO_TX_UNDERRUN_CNT_EN
        check("ucnt_i2s", 64'(ucnt[0]), 64'd3);
        check("ucnt_lj", 64'(ucnt[1]), 64'd2);
`endif
        vld = 3'b111;
        repeat (300) begin tick(); dl = 16'($urandom); dr = 16'($urandom); end
        clear_counts();
        repeat (1024) begin tick(); dl = 16'($urandom); dr = 16'($urandom); end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_xfers%0d", i), 64'(acc[i]), 64'd4);
            check($sformatf("bp_underruns%0d", i), 64'(upulse[i]), 64'd0);
        end
        repeat (1500) begin
            tick();
            vld = 3'($urandom); dl = 16'($urandom); dr = 16'($urandom);
        end
        vld = 3'b111;
        guard = 0;
        while (!((cyc / BD) % FW == 20 && cyc % BD == 2 && full[0]) && guard < 3000) begin
            tick(); guard++;
            dl = 16'($urandom); dr = 16'($urandom);
        end
        check("midframe_reached", 64'(guard < 3000), 64'd1);
        rst_n = 1'b0;
        model_reset();
        vld = 3'b000;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("midreset_out%0d", i), 64'({mclk[i], bclk[i], lrck[i], sd[i], rdy[i], un[i]}), 64'(6'b000010));
`ifdef I2S_STEREO_TX_UNDERRUN_CNT_EN
        check("ucnt_reset", 64'(ucnt[0]), 64'd0);
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        clear_counts();
        while (cyc < 300) tick();
        check("post_reset_i2s_zero", word(0, 1), 64'd0);
        check("post_reset_rep_zero", word(2, 1), 64'd0);
        for (int i = 0; i < 3; i++) check($sformatf("post_reset_unarmed%0d", i), 64'(upulse[i]), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
